// File: rtl/hazard_ctrl.sv
// Pipeline hazard controller: load-use stall, branch flush and data-memory freeze
// with a bounded memory wait that latches into an absorbing HALT state.
module hazard_ctrl #(
    parameter int unsigned TIMEOUT = 64
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        id_ex_memrd,
    input  logic [4:0]  id_ex_rd,
    input  logic [4:0]  if_id_rs,
    input  logic [4:0]  if_id_rs2,
    input  logic        if_id_uses_rs,
    input  logic        if_id_uses_rs2,
    input  logic        branch_taken,
    input  logic        dmem_req,
    input  logic        dmem_ack,
    output logic        pc_we,
    output logic        if_id_we,
    output logic        id_ex_we,
    output logic        ex_mem_we,
    output logic        if_id_flush,
    output logic        id_ex_flush,
    output logic        mem_wb_bubble,
    output logic        halted,
    output logic [1:0]  state,
    output logic [15:0] stall_cnt,
    output logic [15:0] flush_cnt
);

    typedef enum logic [1:0] {
        ST_RUN      = 2'b00,
        ST_MEM_WAIT = 2'b01,
        ST_HALT     = 2'b10
    } state_t;

    localparam logic [7:0] TIMEOUT_C = 8'(TIMEOUT);

    state_t      state_r;
    state_t      state_nxt_s;
    logic [7:0]  wait_cnt_r;
    logic [7:0]  wait_cnt_nxt_s;
    logic        halted_r;
    logic        halted_nxt_s;
    logic [15:0] stall_cnt_r;
    logic [15:0] flush_cnt_r;

    logic        rs_hit_s;
    logic        rs2_hit_s;
    logic        load_use_s;
    logic        freeze_s;
    logic        active_s;
    logic        stall_inc_s;
    logic        flush_inc_s;

    // Saturating 16-bit increment shared by both performance counters.
    function automatic logic [15:0] sat_inc(input logic [15:0] val, input logic en);
        logic [15:0] res;
        if (en && (val != 16'hFFFF)) begin
            res = val + 16'd1;
        end else begin
            res = val;
        end
        return res;
    endfunction

    // Hazard detection from the current pipeline register contents.
    always_comb begin
        rs_hit_s   = if_id_uses_rs  && (id_ex_rd == if_id_rs);
        rs2_hit_s  = if_id_uses_rs2 && (id_ex_rd == if_id_rs2);
        load_use_s = id_ex_memrd && (id_ex_rd != 5'd0) && (rs_hit_s || rs2_hit_s);
        freeze_s   = dmem_req && !dmem_ack;
        active_s   = (state_r == ST_RUN) || (state_r == ST_MEM_WAIT);
    end

    // Stage enables and bubble controls; freeze outranks branch, branch outranks load-use.
    always_comb begin
        pc_we         = 1'b0;
        if_id_we      = 1'b0;
        id_ex_we      = 1'b0;
        ex_mem_we     = 1'b0;
        if_id_flush   = 1'b0;
        id_ex_flush   = 1'b0;
        mem_wb_bubble = 1'b0;
        if (reset) begin
            pc_we = 1'b0;
        end else begin
            case (state_r)
                ST_RUN, ST_MEM_WAIT: begin
                    if (freeze_s) begin
                        mem_wb_bubble = 1'b1;
                    end else if (branch_taken) begin
                        pc_we       = 1'b1;
                        if_id_we    = 1'b1;
                        id_ex_we    = 1'b1;
                        ex_mem_we   = 1'b1;
                        if_id_flush = 1'b1;
                        id_ex_flush = 1'b1;
                    end else if (load_use_s) begin
                        id_ex_we    = 1'b1;
                        ex_mem_we   = 1'b1;
                        id_ex_flush = 1'b1;
                    end else begin
                        pc_we     = 1'b1;
                        if_id_we  = 1'b1;
                        id_ex_we  = 1'b1;
                        ex_mem_we = 1'b1;
                    end
                end
                ST_HALT: begin
                    pc_we = 1'b0;
                end
                default: begin
                    pc_we = 1'b0;
                end
            endcase
        end
    end

    // Next-state logic for the memory-wait watchdog.
    always_comb begin
        state_nxt_s    = state_r;
        wait_cnt_nxt_s = wait_cnt_r;
        halted_nxt_s   = halted_r;
        case (state_r)
            ST_RUN: begin
                if (freeze_s) begin
                    state_nxt_s    = ST_MEM_WAIT;
                    wait_cnt_nxt_s = 8'd1;
                end else begin
                    wait_cnt_nxt_s = 8'd0;
                end
            end
            ST_MEM_WAIT: begin
                // An ack always wins over an expiring timeout.
                if (dmem_ack || !dmem_req) begin
                    state_nxt_s    = ST_RUN;
                    wait_cnt_nxt_s = 8'd0;
                end else if (wait_cnt_r == TIMEOUT_C) begin
                    state_nxt_s  = ST_HALT;
                    halted_nxt_s = 1'b1;
                end else begin
                    wait_cnt_nxt_s = wait_cnt_r + 8'd1;
                end
            end
            ST_HALT: begin
                state_nxt_s = ST_HALT;
            end
            default: begin
                state_nxt_s    = ST_RUN;
                wait_cnt_nxt_s = 8'd0;
            end
        endcase
    end

    // Counter increment conditions.
    always_comb begin
        stall_inc_s = active_s && !pc_we;
        flush_inc_s = if_id_flush;
    end

    // State, watchdog and performance counter registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r     <= ST_RUN;
            wait_cnt_r  <= 8'd0;
            halted_r    <= 1'b0;
            stall_cnt_r <= 16'd0;
            flush_cnt_r <= 16'd0;
        end else begin
            state_r     <= state_nxt_s;
            wait_cnt_r  <= wait_cnt_nxt_s;
            halted_r    <= halted_nxt_s;
            stall_cnt_r <= sat_inc(stall_cnt_r, stall_inc_s);
            flush_cnt_r <= sat_inc(flush_cnt_r, flush_inc_s);
        end
    end

    assign state     = state_r;
    assign halted    = halted_r;
    assign stall_cnt = stall_cnt_r;
    assign flush_cnt = flush_cnt_r;

endmodule

// File: tb/tb_hazard_ctrl.sv
// Scoreboard bench for hazard_ctrl: directed cycles push expected outputs, a negedge
// monitor pops and compares. dut_a uses TIMEOUT=4, dut_b TIMEOUT=255 for saturation.
module tb_hazard_ctrl;

    logic       clk;
    logic       reset;
    logic       id_ex_memrd;
    logic [4:0] id_ex_rd;
    logic [4:0] if_id_rs;
    logic [4:0] if_id_rs2;
    logic       if_id_uses_rs;
    logic       if_id_uses_rs2;
    logic       branch_taken;
    logic       dmem_req;
    logic       dmem_ack;

    logic        a_pc_we, a_if_id_we, a_id_ex_we, a_ex_mem_we;
    logic        a_if_id_flush, a_id_ex_flush, a_mem_wb_bubble, a_halted;
    logic [1:0]  a_state;
    logic [15:0] a_stall_cnt, a_flush_cnt;
    logic        b_pc_we, b_if_id_we, b_id_ex_we, b_ex_mem_we;
    logic        b_if_id_flush, b_id_ex_flush, b_mem_wb_bubble, b_halted;
    logic [1:0]  b_state;
    logic [15:0] b_stall_cnt, b_flush_cnt;

    hazard_ctrl #(.TIMEOUT(4)) dut_a (
        .clk(clk), .reset(reset), .id_ex_memrd(id_ex_memrd), .id_ex_rd(id_ex_rd),
        .if_id_rs(if_id_rs), .if_id_rs2(if_id_rs2), .if_id_uses_rs(if_id_uses_rs),
        .if_id_uses_rs2(if_id_uses_rs2), .branch_taken(branch_taken),
        .dmem_req(dmem_req), .dmem_ack(dmem_ack),
        .pc_we(a_pc_we), .if_id_we(a_if_id_we), .id_ex_we(a_id_ex_we), .ex_mem_we(a_ex_mem_we),
        .if_id_flush(a_if_id_flush), .id_ex_flush(a_id_ex_flush), .mem_wb_bubble(a_mem_wb_bubble),
        .halted(a_halted), .state(a_state), .stall_cnt(a_stall_cnt), .flush_cnt(a_flush_cnt)
    );

    hazard_ctrl #(.TIMEOUT(255)) dut_b (
        .clk(clk), .reset(reset), .id_ex_memrd(id_ex_memrd), .id_ex_rd(id_ex_rd),
        .if_id_rs(if_id_rs), .if_id_rs2(if_id_rs2), .if_id_uses_rs(if_id_uses_rs),
        .if_id_uses_rs2(if_id_uses_rs2), .branch_taken(branch_taken),
        .dmem_req(dmem_req), .dmem_ack(dmem_ack),
        .pc_we(b_pc_we), .if_id_we(b_if_id_we), .id_ex_we(b_id_ex_we), .ex_mem_we(b_ex_mem_we),
        .if_id_flush(b_if_id_flush), .id_ex_flush(b_id_ex_flush), .mem_wb_bubble(b_mem_wb_bubble),
        .halted(b_halted), .state(b_state), .stall_cnt(b_stall_cnt), .flush_cnt(b_flush_cnt)
    );

    // ctrl = {pc_we, if_id_we, id_ex_we, ex_mem_we, if_id_flush, id_ex_flush, mem_wb_bubble}
    localparam logic [6:0] C_ZERO = 7'b0000_000;
    localparam logic [6:0] C_NORM = 7'b1111_000;
    localparam logic [6:0] C_FRZ  = 7'b0000_001;
    localparam logic [6:0] C_BR   = 7'b1111_110;
    localparam logic [6:0] C_LU   = 7'b0011_010;

    typedef struct packed {
        logic [6:0]  ctrl;
        logic [1:0]  st;
        logic        hlt;
        logic [15:0] sc;
        logic [15:0] fc;
        logic        use_b;
        logic [7:0]  id;
    } exp_t;

    exp_t sb_q[$];
    int   checks;
    int   errors;
    int   step_id;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [7:0] id,
                         input logic [15:0] act, input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL step %0d %s: got %h expected %h", id, name, act, exp);
        end
    endtask

    // Monitor: outputs are valid every cycle, so any pending expectation is compared at negedge.
    always @(negedge clk) begin
        exp_t       e;
        logic [6:0] ctrl;
        if (sb_q.size() > 0) begin
            e = sb_q.pop_front();
            if (e.use_b) begin
                ctrl = {b_pc_we, b_if_id_we, b_id_ex_we, b_ex_mem_we,
                        b_if_id_flush, b_id_ex_flush, b_mem_wb_bubble};
                check("ctrl",      e.id, {9'd0, ctrl},     {9'd0, e.ctrl});
                check("state",     e.id, {14'd0, b_state}, {14'd0, e.st});
                check("halted",    e.id, {15'd0, b_halted}, {15'd0, e.hlt});
                check("stall_cnt", e.id, b_stall_cnt,      e.sc);
                check("flush_cnt", e.id, b_flush_cnt,      e.fc);
            end else begin
                ctrl = {a_pc_we, a_if_id_we, a_id_ex_we, a_ex_mem_we,
                        a_if_id_flush, a_id_ex_flush, a_mem_wb_bubble};
                check("ctrl",      e.id, {9'd0, ctrl},     {9'd0, e.ctrl});
                check("state",     e.id, {14'd0, a_state}, {14'd0, e.st});
                check("halted",    e.id, {15'd0, a_halted}, {15'd0, e.hlt});
                check("stall_cnt", e.id, a_stall_cnt,      e.sc);
                check("flush_cnt", e.id, a_flush_cnt,      e.fc);
            end
        end
    end

    task automatic drive(input logic rst, input logic memrd, input logic [4:0] rd,
                         input logic [4:0] rs, input logic [4:0] rs2, input logic urs,
                         input logic urs2, input logic br, input logic req, input logic ack);
        @(posedge clk);
        #1;
        reset          = rst;
        id_ex_memrd    = memrd;
        id_ex_rd       = rd;
        if_id_rs       = rs;
        if_id_rs2      = rs2;
        if_id_uses_rs  = urs;
        if_id_uses_rs2 = urs2;
        branch_taken   = br;
        dmem_req       = req;
        dmem_ack       = ack;
    endtask

    task automatic step(input logic rst, input logic memrd, input logic [4:0] rd,
                        input logic [4:0] rs, input logic [4:0] rs2, input logic urs,
                        input logic urs2, input logic br, input logic req, input logic ack,
                        input logic [6:0] ctrl, input logic [1:0] st, input logic hlt,
                        input logic [15:0] sc, input logic [15:0] fc, input logic use_b);
        exp_t e;
        drive(rst, memrd, rd, rs, rs2, urs, urs2, br, req, ack);
        step_id++;
        e.ctrl  = ctrl;
        e.st    = st;
        e.hlt   = hlt;
        e.sc    = sc;
        e.fc    = fc;
        e.use_b = use_b;
        e.id    = 8'(step_id);
        sb_q.push_back(e);
    endtask

    initial begin
        checks  = 0;
        errors  = 0;
        step_id = 0;
        reset = 1'b1; id_ex_memrd = 1'b0; id_ex_rd = 5'd0; if_id_rs = 5'd0; if_id_rs2 = 5'd0;
        if_id_uses_rs = 1'b0; if_id_uses_rs2 = 1'b0; branch_taken = 1'b0;
        dmem_req = 1'b0; dmem_ack = 1'b0;
        repeat (2) @(posedge clk);

        //   rst  memrd rd     rs     rs2    urs   urs2  br    req   ack   ctrl    st     hlt   sc        fc     b
        step(1'b1, 1'b1, 5'd5, 5'd5, 5'd0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, C_ZERO, 2'd0, 1'b0, 16'd0,  16'd0, 1'b0);
        step(1'b0, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, C_NORM, 2'd0, 1'b0, 16'd0,  16'd0, 1'b0);
        // load-use through rs, then through rs2; rd=0 and unused-source cases do not stall
        step(1'b0, 1'b1, 5'd5, 5'd5, 5'd0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, C_LU,   2'd0, 1'b0, 16'd0,  16'd0, 1'b0);
        step(1'b0, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, C_NORM, 2'd0, 1'b0, 16'd1,  16'd0, 1'b0);
        step(1'b0, 1'b1, 5'd7, 5'd0, 5'd7, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, C_LU,   2'd0, 1'b0, 16'd1,  16'd0, 1'b0);
        step(1'b0, 1'b1, 5'd0, 5'd0, 5'd0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, C_NORM, 2'd0, 1'b0, 16'd2,  16'd0, 1'b0);
        step(1'b0, 1'b1, 5'd5, 5'd5, 5'd5, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, C_NORM, 2'd0, 1'b0, 16'd2,  16'd0, 1'b0);
        // branch beats load-use
        step(1'b0, 1'b1, 5'd5, 5'd5, 5'd0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, C_BR,   2'd0, 1'b0, 16'd2,  16'd0, 1'b0);
        step(1'b0, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, C_NORM, 2'd0, 1'b0, 16'd2,  16'd1, 1'b0);
        // freeze with ack on the fourth cycle
        step(1'b0, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, C_FRZ,  2'd0, 1'b0, 16'd2,  16'd1, 1'b0);
        step(1'b0, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, C_FRZ,  2'd1, 1'b0, 16'd3,  16'd1, 1'b0);
        step(1'b0, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, C_FRZ,  2'd1, 1'b0, 16'd4,  16'd1, 1'b0);
        step(1'b0, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, C_NORM, 2'd1, 1'b0, 16'd5,  16'd1, 1'b0);
        step(1'b0, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, C_NORM, 2'd0, 1'b0, 16'd5,  16'd1, 1'b0);
        // ack exactly when wait_cnt reaches TIMEOUT
        step(1'b0, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, C_FRZ,  2'd0, 1'b0, 16'd5,  16'd1, 1'b0);
        step(1'b0, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, C_FRZ,  2'd1, 1'b0, 16'd6,  16'd1, 1'b0);
        step(1'b0, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, C_FRZ,  2'd1, 1'b0, 16'd7,  16'd1, 1'b0);
        step(1'b0, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, C_FRZ,  2'd1, 1'b0, 16'd8,  16'd1, 1'b0);
        step(1'b0, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, C_NORM, 2'd1, 1'b0, 16'd9,  16'd1, 1'b0);
        step(1'b0, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, C_NORM, 2'd0, 1'b0, 16'd9,  16'd1, 1'b0);
        // abort from MEM_WAIT while a branch redirects
        step(1'b0, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, C_FRZ,  2'd0, 1'b0, 16'd9,  16'd1, 1'b0);
        step(1'b0, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, C_BR,   2'd1, 1'b0, 16'd10, 16'd1, 1'b0);
        step(1'b0, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, C_NORM, 2'd0, 1'b0, 16'd10, 16'd2, 1'b0);
        // timeout: halt after the fifth frozen edge, absorbing until reset
        step(1'b0, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, C_FRZ,  2'd0, 1'b0, 16'd10, 16'd2, 1'b0);
        step(1'b0, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, C_FRZ,  2'd1, 1'b0, 16'd11, 16'd2, 1'b0);
        step(1'b0, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, C_FRZ,  2'd1, 1'b0, 16'd12, 16'd2, 1'b0);
        step(1'b0, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, C_FRZ,  2'd1, 1'b0, 16'd13, 16'd2, 1'b0);
        step(1'b0, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, C_FRZ,  2'd1, 1'b0, 16'd14, 16'd2, 1'b0);
        step(1'b0, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, C_ZERO, 2'd2, 1'b1, 16'd15, 16'd2, 1'b0);
        step(1'b0, 1'b1, 5'd5, 5'd5, 5'd0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, C_ZERO, 2'd2, 1'b1, 16'd15, 16'd2, 1'b0);
        step(1'b1, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, C_ZERO, 2'd2, 1'b1, 16'd15, 16'd2, 1'b0);
        step(1'b0, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, C_NORM, 2'd0, 1'b0, 16'd0,  16'd0, 1'b0);

        // Preload dut_b stall_cnt to FFFF: 257 blocks of 255 frozen cycles plus one abort.
        for (int blk = 0; blk < 257; blk++) begin
            for (int c = 0; c < 255; c++) begin
                drive(1'b0, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
            end
            drive(1'b0, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        end
        step(1'b0, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, C_FRZ,  2'd0, 1'b0, 16'hFFFF, 16'd0, 1'b1);
        step(1'b0, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, C_FRZ,  2'd1, 1'b0, 16'hFFFF, 16'd0, 1'b1);
        step(1'b0, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, C_NORM, 2'd1, 1'b0, 16'hFFFF, 16'd0, 1'b1);
        step(1'b0, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, C_NORM, 2'd0, 1'b0, 16'hFFFF, 16'd0, 1'b1);

        repeat (3) @(posedge clk);
        checks++;
        if (sb_q.size() != 0) begin
            errors++;
            $display("FAIL drain: %0d expectations left, required 0", sb_q.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", checks, errors);
        $finish;
    end

endmodule

// File: doc/hazard_ctrl.md
HAZARD_CTRL -- requirements
Module: hazard_ctrl

Interface
REQ-001 Parameter TIMEOUT, default 64, range 1..255: maximum MEM_WAIT cycles before halt.
REQ-002 clk  in  1  single clock; all state updates on rising edge.
REQ-003 reset  in  1  synchronous, active-high.
REQ-004 id_ex_memrd  in  1  instruction in ID/EX is a load.
REQ-005 id_ex_rd  in  5  destination register of the ID/EX instruction.
REQ-006 if_id_rs, if_id_rs2  in  5 each  source registers of the IF/ID instruction.
REQ-007 if_id_uses_rs, if_id_uses_rs2  in  1 each  the IF/ID instruction reads that source.
REQ-008 branch_taken  in  1  EX-stage redirect.
REQ-009 dmem_req, dmem_ack  in  1 each  MEM-stage access request and completion.
REQ-010 pc_we, if_id_we, id_ex_we, ex_mem_we  out  1 each  stage register write enables.
REQ-011 if_id_flush, id_ex_flush, mem_wb_bubble  out  1 each  bubble insertion.
REQ-012 halted  out  1  sticky timeout indication.
REQ-013 state  out  2  FSM state: RUN=00, MEM_WAIT=01, HALT=10.
REQ-014 stall_cnt, flush_cnt  out  16 each  performance counters.

Function
REQ-015 Control outputs SHALL be combinational from state and current inputs; state, wait_cnt (8-bit, internal), halted and counters SHALL be registered.
REQ-016 load_use = id_ex_memrd & (id_ex_rd != 0) & ((if_id_uses_rs & id_ex_rd == if_id_rs) | (if_id_uses_rs2 & id_ex_rd == if_id_rs2)).
REQ-017 freeze = dmem_req & ~dmem_ack.
REQ-018 In RUN or MEM_WAIT, priority SHALL be freeze > branch_taken > load_use > normal.
REQ-019 freeze: pc_we = if_id_we = id_ex_we = ex_mem_we = 0, mem_wb_bubble = 1, both flushes = 0.
REQ-020 branch_taken (no freeze): all *_we = 1, if_id_flush = 1, id_ex_flush = 1, mem_wb_bubble = 0.
REQ-021 load_use (no freeze, no branch): pc_we = 0, if_id_we = 0, id_ex_flush = 1, id_ex_we = 1, ex_mem_we = 1, if_id_flush = 0, mem_wb_bubble = 0.
REQ-022 normal: all *_we = 1, all flush/bubble = 0.
REQ-023 HALT: all *_we = 0, all flush/bubble = 0, regardless of inputs.
REQ-024 RUN -> MEM_WAIT when freeze; wait_cnt <= 1.
REQ-025 MEM_WAIT -> RUN when dmem_ack = 1 (ack cycle SHALL use RUN priority with freeze = 0); wait_cnt <= 0.
REQ-026 MEM_WAIT -> RUN when dmem_req = 0 (abort); wait_cnt <= 0.
REQ-027 MEM_WAIT with freeze and wait_cnt == TIMEOUT -> HALT, halted <= 1; otherwise wait_cnt <= wait_cnt + 1.
REQ-028 An ack arriving in the same cycle that wait_cnt == TIMEOUT SHALL win: -> RUN, no halt.
REQ-029 HALT SHALL be absorbing until reset.
REQ-030 stall_cnt SHALL increment each non-reset cycle with pc_we = 0 in RUN or MEM_WAIT, saturating at 16'hFFFF.
REQ-031 flush_cnt SHALL increment each cycle with if_id_flush = 1, saturating at 16'hFFFF.
REQ-032 Load-use with id_ex_rd = 0 SHALL NOT stall.

Reset
REQ-033 reset = 1 at a rising edge SHALL set state = RUN, wait_cnt = 0, halted = 0, stall_cnt = 0, flush_cnt = 0, overriding all other transitions including HALT.
REQ-034 While reset = 1, all *_we = 0, all flush/bubble = 0.

Verification
REQ-035 id_ex_memrd = 1, id_ex_rd = 5, if_id_rs = 5, uses_rs = 1 -> pc_we = 0, if_id_we = 0, id_ex_flush = 1 for exactly that cycle; stall_cnt +1. Same with id_ex_rd = 0 -> no stall.
REQ-036 branch_taken = 1 concurrent with a load_use condition -> if_id_flush = id_ex_flush = 1, pc_we = 1; flush_cnt +1, stall_cnt unchanged.
REQ-037 dmem_req = 1, ack after 3 cycles -> 3 freeze cycles (state 00, 01, 01), state = 01 in the ack cycle with enables = 1, then state = 00; stall_cnt +3.
REQ-038 TIMEOUT = 4, dmem_req held, no ack -> halted = 1, state = 10 after the 5th rising edge; all enables stay 0 until reset; then state = 00, counters = 0.
REQ-039 TIMEOUT = 4, ack asserted in the cycle where wait_cnt = 4 -> returns to RUN, halted stays 0.
REQ-040 Preload stall_cnt to 16'hFFFF via continuous freeze -> further stall cycles leave it at 16'hFFFF.
